requant_lane_pipe: RTL and testbench
====================================

// Module: requant_lane_pipe
// PURPOSE
//   Multi-lane streaming requantiser: arithmetic right shift, selectable rounding, saturation.
//   Converts LANES wide accumulator words (IN_W) to narrow activations (OUT_W).
//   Sits between the NPU accumulator array and the activation write-back buffer.
//   Uses a valid/ready handshake and a 2-stage pipeline with full back-pressure.
// PARAMETERS
//   LANES  4   parallel lanes per beat
//   IN_W   32  signed input width per lane
//   OUT_W  8   signed output width per lane; must satisfy OUT_W < IN_W
//   SH_W   6   shift-amount width
// PORTS
//   i_clk         in   1              clock, rising edge
//   i_rst_n       in   1              asynchronous active-low reset
//   i_vld         in   1              input beat valid
//   o_rdy         out  1              input beat accepted when i_vld & o_rdy
//   i_dat         in   LANES*IN_W     lane k = i_dat[k*IN_W +: IN_W], signed
//   i_shift_en    in   1              0 = no shift and no rounding; saturation still applied
//   i_shift       in   SH_W           right-shift amount, sampled with the beat
//   i_round_mode  in   2              00 trunc, 01 half-up, 10 half-even, 11 half-away-from-zero
//   o_vld         out  1              output beat valid
//   i_rdy         in   1              downstream ready
//   o_dat         out  LANES*OUT_W    lane k = o_dat[k*OUT_W +: OUT_W], signed
//   o_sat         out  LANES          per-lane flag: that lane was clipped in this beat
//   i_sat_clr     in   1              clears the saturation counter (see CONFIGURATION)
//   o_sat_cnt     out  16             count of saturated lanes (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: o_vld=0, o_dat=0, o_sat=0, o_sat_cnt=0, both pipeline stages empty. o_rdy=1 after reset.
//   - Handshake: stage advances when it is empty or the stage below it advances.
//     o_rdy = ~s1_vld | s2_adv, where s2_adv = ~o_vld | i_rdy.
//     Holds 2 beats while stalled. Zero bubbles at full throughput. Beat order is preserved.
//   - Held data: o_dat, o_sat and o_vld stay stable while o_vld & ~i_rdy.
//     i_dat and all config inputs are ignored unless a transfer occurs (i_vld & o_rdy).
//   - Latency: accept at edge N -> o_vld at edge N+2 when no stall.
//   - Config is per beat: shift, shift_en and mode travel with the data. No cross-beat state.
//   - Stage 1, per lane:
//     - Effective shift s = min(i_shift, IN_W-1); s = 0 when i_shift_en = 0.
//     - q = x >>> s. guard g = x[s-1]. sticky t = |x[s-2:0]. lsb l = q[0].
//     - When s = 0: g = 0 and t = 0. When s = 1: t = 0.
//     - inc = 00: 0 | 01: g | 10: g & (t | l) | 11: g & (t | ~x[IN_W-1]).
//     - r = q + inc, computed at IN_W+1 bits so no wrap occurs.
//   - Stage 2, per lane:
//     - r > 2^(OUT_W-1)-1 -> MAX, sat = 1.
//     - r < -2^(OUT_W-1) -> MIN, sat = 1.
//     - Otherwise r[OUT_W-1:0], sat = 0.
//   - Reset mid-operation: all in-flight beats are discarded and no partial output is produced.
// CONFIGURATION
//   - REQUANT_SAT_CNT_EN defined:
//     - o_sat_cnt adds popcount(o_sat) on every output transfer (o_vld & i_rdy).
//     - The counter saturates at 16'hFFFF and does not wrap.
//     - i_sat_clr zeroes the counter. If clear and a transfer occur in the same cycle, clear wins:
//       result is 0 and the transfer's count is dropped.
//   - REQUANT_SAT_CNT_EN undefined:
//     - o_sat_cnt is tied to 0 and i_sat_clr is ignored. No counter flops are built.
//     - Ports are kept so the interface is stable.
// TESTING (LANES=4, IN_W=32, OUT_W=8)
//   1. Rounding: x=40, s=4:
//      - mode 00 -> 2, mode 01 -> 3, mode 10 -> 2.
//      - x=56: mode 10 -> 4.
//      - x=-40, mode 11 -> -3; x=-40, mode 01 -> -2.
//   2. Saturation: x=0x10000, s=4 -> 127, o_sat=1. x=-0x10000, s=4 -> -128, o_sat=1.
//      x=2032, s=4, mode 01 -> 127, o_sat=0.
//   3. Clamp and bypass:
//      - i_shift=40, x=0x7FFFFFFF, mode 01 -> s=31, result 1.
//      - shift_en=0, x=100 -> 100, o_sat=0.
//      - shift_en=0, x=300 -> 127, o_sat=1.
//   4. Back-pressure: stream 6 beats with i_rdy low for cycles 3-7.
//      - o_rdy drops after 2 beats are held.
//      - All 6 beats arrive in order, no duplicates; o_dat is stable while stalled.
//   5. Reset mid-stream: assert i_rst_n=0 with 2 beats in flight.
//      - o_vld=0 and o_dat=0 immediately; no stale beat after release.
//   6. REQUANT_SAT_CNT_EN:
//      - 3 beats with 2 saturated lanes each -> o_sat_cnt=6.
//      - i_sat_clr together with a transfer -> 0.
//      - Preload near 16'hFFFF -> holds 16'hFFFF.

Source files
------------

// File: rtl/requant_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module  : requant_lane_pipe
// Brief   : Multi-lane requantiser (shift, round, saturate) with a 2-stage
//           valid/ready pipeline. Define REQUANT_SAT_CNT_EN to build the
//           saturated-lane counter behind o_sat_cnt.
// Rev     : 1.0
// ============================================================================
module requant_lane_pipe #(
  parameter int LANES = 4,
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int SH_W  = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_vld,
  output logic                   o_rdy,
  input  logic [LANES*IN_W-1:0]  i_dat,
  input  logic                   i_shift_en,
  input  logic [SH_W-1:0]        i_shift,
  input  logic [1:0]             i_round_mode,
  output logic                   o_vld,
  input  logic                   i_rdy,
  output logic [LANES*OUT_W-1:0] o_dat,
  output logic [LANES-1:0]       o_sat,
  input  logic                   i_sat_clr,
  output logic [15:0]            o_sat_cnt
);

  localparam logic [1:0]          c_rm_trunc     = 2'b00;
  localparam logic [1:0]          c_rm_half_up   = 2'b01;
  localparam logic [1:0]          c_rm_half_even = 2'b10;
  localparam logic [1:0]          c_rm_half_away = 2'b11;
  localparam logic [SH_W-1:0]     c_sh_max       = SH_W'(IN_W - 1);
  localparam logic signed [IN_W:0] c_sat_max     = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] c_sat_min     = -c_sat_max - 1;

  logic                   r_s1_vld;
  logic signed [IN_W:0]   r_s1_r [LANES];
  logic                   r_o_vld;
  logic [LANES*OUT_W-1:0] r_o_dat;
  logic [LANES-1:0]       r_o_sat;

  logic                   w_s2_adv;
  logic [SH_W-1:0]        w_s;
  logic signed [IN_W:0]   w_r [LANES];
  logic [LANES*OUT_W-1:0] w_o_dat;
  logic [LANES-1:0]       w_o_sat;

  assign w_s2_adv = ~r_o_vld | i_rdy;
  assign o_rdy    = ~r_s1_vld | w_s2_adv;
  assign o_vld    = r_o_vld;
  assign o_dat    = r_o_dat;
  assign o_sat    = r_o_sat;

  always_comb begin
    w_s = '0;
    if (i_shift_en) begin
      w_s = (i_shift > c_sh_max) ? c_sh_max : i_shift;
    end
  end

  // w_half selects bit s-1 (the guard); everything below it forms the sticky bit.
  for (genvar k = 0; k < LANES; k++) begin : g_lane_round
    logic signed [IN_W-1:0] w_x;
    logic signed [IN_W-1:0] w_q;
    logic [IN_W-1:0]        w_half;
    logic                   w_g;
    logic                   w_t;
    logic                   w_inc;

    assign w_x    = $signed(i_dat[k*IN_W +: IN_W]);
    assign w_q    = w_x >>> w_s;
    assign w_half = (IN_W'(1) << w_s) >> 1;
    assign w_g    = |(w_x & w_half);
    assign w_t    = (w_half != '0) && (|(w_x & (w_half - IN_W'(1))));

    always_comb begin
      w_inc = 1'b0;
      case (i_round_mode)
        c_rm_trunc:     w_inc = 1'b0;
        c_rm_half_up:   w_inc = w_g;
        c_rm_half_even: w_inc = w_g & (w_t | w_q[0]);
        c_rm_half_away: w_inc = w_g & (w_t | ~w_x[IN_W-1]);
        default:        w_inc = 1'b0;
      endcase
    end

    assign w_r[k] = {w_q[IN_W-1], w_q} + {{IN_W{1'b0}}, w_inc};
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane_sat
    logic [OUT_W-1:0] w_lane;
    logic             w_lane_sat;

    always_comb begin
      w_lane     = r_s1_r[k][OUT_W-1:0];
      w_lane_sat = 1'b0;
      if (r_s1_r[k] > c_sat_max) begin
        w_lane     = {1'b0, {(OUT_W-1){1'b1}}};
        w_lane_sat = 1'b1;
      end else if (r_s1_r[k] < c_sat_min) begin
        w_lane     = {1'b1, {(OUT_W-1){1'b0}}};
        w_lane_sat = 1'b1;
      end
    end

    assign w_o_dat[k*OUT_W +: OUT_W] = w_lane;
    assign w_o_sat[k]                = w_lane_sat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_vld <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r_s1_r[k] <= '0;
      end
    end else if (o_rdy) begin
      r_s1_vld <= i_vld;
      if (i_vld) begin
        r_s1_r <= w_r;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_o_vld <= 1'b0;
      r_o_dat <= '0;
      r_o_sat <= '0;
    end else if (w_s2_adv) begin
      r_o_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_o_dat <= w_o_dat;
        r_o_sat <= w_o_sat;
      end
    end
  end

`ifdef REQUANT_SAT_CNT_EN
  logic [15:0] r_sat_cnt;
  logic [16:0] w_pop;
  logic [16:0] w_cnt_sum;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < LANES; k++) begin
      w_pop = w_pop + 17'(r_o_sat[k]);
    end
  end

  assign w_cnt_sum = {1'b0, r_sat_cnt} + w_pop;

  // Clear takes priority over a same-cycle transfer; the sum sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sat_cnt <= '0;
    end else if (i_sat_clr) begin
      r_sat_cnt <= '0;
    end else if (r_o_vld && i_rdy) begin
      r_sat_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign o_sat_cnt = r_sat_cnt;
`else
  logic w_unused_sat_clr;
  assign w_unused_sat_clr = i_sat_clr;
  assign o_sat_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_requant_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_requant_lane_pipe
// Brief   : Self-checking bench for requant_lane_pipe against an arithmetic
//           reference model and an in-order expected-beat queue.
// Rev     : 1.0
// ============================================================================
module tb_requant_lane_pipe;

  localparam int LANES = 4;
  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int SH_W  = 6;
  localparam longint c_max = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint c_min = -(longint'(1) << (OUT_W - 1));

  logic                   i_clk = 1'b0;
  logic                   i_rst_n = 1'b0;
  logic                   i_vld = 1'b0;
  logic                   o_rdy;
  logic [LANES*IN_W-1:0]  i_dat = '0;
  logic                   i_shift_en = 1'b0;
  logic [SH_W-1:0]        i_shift = '0;
  logic [1:0]             i_round_mode = '0;
  logic                   o_vld;
  logic                   i_rdy = 1'b0;
  logic [LANES*OUT_W-1:0] o_dat;
  logic [LANES-1:0]       o_sat;
  logic                   i_sat_clr = 1'b0;
  logic [15:0]            o_sat_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int rx_cnt = 0;
  bit rdy_rand = 1'b0;

  typedef struct {
    logic [LANES*OUT_W-1:0] dat;
    logic [LANES-1:0]       sat;
  } beat_t;

  beat_t  exp_q[$];
  beat_t  front;
  longint model_cnt = 0;
  int     pop_n;
  bit     held_v = 1'b0;

  always #5 i_clk = ~i_clk;

  requant_lane_pipe #(
    .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_dat(i_dat), .i_shift_en(i_shift_en), .i_shift(i_shift),
    .i_round_mode(i_round_mode), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_sat(o_sat), .i_sat_clr(i_sat_clr), .o_sat_cnt(o_sat_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: floor division plus remainder-versus-half rounding, then clip.
  function automatic logic [OUT_W:0] ref_lane(input longint x, input bit en, input int sh, input int md);
    longint d, rem, q, half, r;
    int s;
    s    = en ? ((sh > IN_W - 1) ? IN_W - 1 : sh) : 0;
    d    = longint'(1) << s;
    rem  = ((x % d) + d) % d;
    q    = (x - rem) / d;
    half = d / 2;
    r    = q;
    if (s > 0) begin
      case (md)
        1: if (rem >= half) r = q + 1;
        2: if (rem > half || (rem == half && (q % 2) != 0)) r = q + 1;
        3: if (rem > half || (rem == half && x >= 0)) r = q + 1;
        default: r = q;
      endcase
    end
    if (r > c_max) return {1'b1, OUT_W'(c_max)};
    if (r < c_min) return {1'b1, OUT_W'(c_min)};
    return {1'b0, OUT_W'(r)};
  endfunction

  function automatic beat_t exp_beat(input logic [LANES*IN_W-1:0] d, input bit en, input int sh, input int md);
    beat_t b;
    logic [OUT_W:0] v;
    for (int k = 0; k < LANES; k++) begin
      v = ref_lane(longint'($signed(d[k*IN_W +: IN_W])), en, sh, md);
      b.dat[k*OUT_W +: OUT_W] = v[OUT_W-1:0];
      b.sat[k] = v[OUT_W];
    end
    return b;
  endfunction

  function automatic logic [LANES*IN_W-1:0] pack(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic int rand_x();
    case ($urandom_range(0, 3))
      0: return int'($urandom);
      1: return int'($urandom_range(0, 8191)) - 4096;
      2: return int'($urandom_range(0, 131071)) - 65536;
      default: return (int'($urandom_range(0, 300)) - 150) * 16 + 8;
    endcase
  endfunction

  // Single compare process: outputs against the queue head, counter against its model.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_q.delete();
      model_cnt = 0;
      held_v    = 1'b0;
    end else begin
      check("sat_cnt", 64'(o_sat_cnt), 64'(model_cnt));
      if (held_v) check("held_vld", 64'(o_vld), 64'd1);
      held_v = o_vld && !i_rdy;
      pop_n  = 0;
      if (o_vld) begin
        check("beat_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          front = exp_q[0];
          check("o_dat", 64'(o_dat), 64'(front.dat));
          check("o_sat", 64'(o_sat), 64'(front.sat));
          if (i_rdy) begin
            void'(exp_q.pop_front());
            rx_cnt++;
            pop_n = $countones(front.sat);
          end
        end
      end
`ifdef REQUANT_SAT_CNT_EN
      if (i_sat_clr) model_cnt = 0;
      else if (o_vld && i_rdy) model_cnt = (model_cnt + pop_n > 65535) ? 65535 : model_cnt + pop_n;
`else
      model_cnt = 0;
`endif
      if (i_vld && o_rdy) exp_q.push_back(exp_beat(i_dat, i_shift_en, int'(i_shift), int'(i_round_mode)));
    end
  end

  always @(posedge i_clk) begin
    #1;
    if (rdy_rand) begin
      i_rdy     = ($urandom_range(0, 3) != 0);
      i_sat_clr = ($urandom_range(0, 63) == 0);
    end
  end

  task automatic send(input logic [LANES*IN_W-1:0] d, input bit en, input int sh, input int md);
    int guard;
    guard        = 0;
    i_vld        = 1'b1;
    i_dat        = d;
    i_shift_en   = en;
    i_shift      = SH_W'(sh);
    i_round_mode = 2'(md);
    @(negedge i_clk);
    while (!o_rdy && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_rdy) check("send_timeout", 64'(o_rdy), 64'd1);
    @(posedge i_clk);
    #1;
    i_vld        = 1'b0;
    i_dat        = {$urandom, $urandom, $urandom, $urandom};
    i_shift      = SH_W'($urandom);
    i_round_mode = 2'($urandom);
    i_shift_en   = 1'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    @(negedge i_clk);
    while ((exp_q.size() != 0 || o_vld) && guard < 300) begin
      @(negedge i_clk);
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    int rx0;
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rx0;
    idle(3);
    check("rst_o_vld", 64'(o_vld), 64'd0);
    check("rst_o_dat", 64'(o_dat), 64'd0);
    check("rst_o_sat", 64'(o_sat), 64'd0);
    check("rst_o_cnt", 64'(o_sat_cnt), 64'd0);
    check("rst_o_rdy", 64'(o_rdy), 64'd1);
    i_rst_n = 1'b1;
    i_rdy   = 1'b1;
    idle(2);

    // Hand-computed pins for the reference model.
    check("pin_trunc",      64'(ref_lane(40, 1, 4, 0)), 64'h002);
    check("pin_half_up",    64'(ref_lane(40, 1, 4, 1)), 64'h003);
    check("pin_even_40",    64'(ref_lane(40, 1, 4, 2)), 64'h002);
    check("pin_even_56",    64'(ref_lane(56, 1, 4, 2)), 64'h004);
    check("pin_away_n40",   64'(ref_lane(-40, 1, 4, 3)), 64'h0FD);
    check("pin_up_n40",     64'(ref_lane(-40, 1, 4, 1)), 64'h0FE);
    check("pin_sat_pos",    64'(ref_lane(65536, 1, 4, 0)), 64'h17F);
    check("pin_sat_neg",    64'(ref_lane(-65536, 1, 4, 0)), 64'h180);
    check("pin_edge_2032",  64'(ref_lane(2032, 1, 4, 1)), 64'h07F);
    check("pin_clamp_sh",   64'(ref_lane(64'h7FFFFFFF, 1, 40, 1)), 64'h001);
    check("pin_bypass_100", 64'(ref_lane(100, 0, 4, 1)), 64'h064);
    check("pin_bypass_300", 64'(ref_lane(300, 0, 4, 1)), 64'h17F);

    // Directed rounding, saturation, clamp and bypass beats.
    send(pack(40, -40, 56, 2032), 1, 4, 0);
    send(pack(40, -40, 2032, 32'h10000), 1, 4, 1);
    send(pack(40, 56, -56, -32'sh10000), 1, 4, 2);
    send(pack(-40, 40, 32'h10000, -32'sh10000), 1, 4, 3);
    send(pack(32'h7FFFFFFF, 32'h80000000, 1, -1), 1, 40, 1);
    send(pack(100, 300, -300, -128), 0, 4, 1);
    send(pack(127, -129, 24, -24), 1, 0, 3);
    drain();

    // Back-pressure: six beats, downstream stalled for cycles 3..7.
    rx0 = rx_cnt;
    fork
      for (int b = 0; b < 6; b++) send(pack(rand_x(), rand_x(), rand_x(), rand_x()), 1, 4, b % 4);
      begin
        for (int c = 0; c < 12; c++) begin
          i_rdy = !(c >= 3 && c <= 7);
          if (c == 5) begin
            @(negedge i_clk);
            check("bp_o_rdy_low", 64'(o_rdy), 64'd0);
            check("bp_o_vld_held", 64'(o_vld), 64'd1);
          end
          @(posedge i_clk);
          #1;
        end
        i_rdy = 1'b1;
      end
    join
    drain();
    check("bp_six_beats", 64'(rx_cnt - rx0), 64'd6);

    // Randomised traffic with random downstream ready and clear pulses.
    rdy_rand = 1'b1;
    for (int b = 0; b < 400; b++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(pack(rand_x(), rand_x(), rand_x(), rand_x()),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 63)),
           int'($urandom_range(0, 3)));
    end
    rdy_rand  = 1'b0;
    i_rdy     = 1'b1;
    i_sat_clr = 1'b0;
    drain();

    // Reset with two beats in flight.
    i_rdy = 1'b0;
    send(pack(40, 41, 42, 43), 1, 1, 1);
    send(pack(65536, 5, 6, 7), 1, 4, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_o_vld", 64'(o_vld), 64'd0);
    check("mid_rst_o_dat", 64'(o_dat), 64'd0);
    check("mid_rst_o_sat", 64'(o_sat), 64'd0);
    check("mid_rst_o_rdy", 64'(o_rdy), 64'd1);
    idle(2);
    i_rst_n = 1'b1;
    i_rdy   = 1'b1;
    idle(5);
    check("post_rst_no_stale", 64'(o_vld), 64'd0);

`ifdef REQUANT_SAT_CNT_EN
    i_sat_clr = 1'b1;
    idle(1);
    i_sat_clr = 1'b0;
    for (int b = 0; b < 3; b++) send(pack(65536, -65536, 5, 7), 1, 4, 0);
    drain();
    check("cnt_six", 64'(o_sat_cnt), 64'd6);

    i_rdy = 1'b0;
    send(pack(65536, 9, 9, 9), 1, 4, 0);
    idle(2);
    i_rdy     = 1'b1;
    i_sat_clr = 1'b1;
    idle(1);
    i_sat_clr = 1'b0;
    check("cnt_clr_wins", 64'(o_sat_cnt), 64'd0);
    drain();

    for (int b = 0; b < 16384; b++) send(pack(65536, -65536, 65536, -65536), 1, 4, 0);
    drain();
    check("cnt_sat_ffff", 64'(o_sat_cnt), 64'hFFFF);
    send(pack(65536, -65536, 65536, -65536), 1, 4, 0);
    drain();
    check("cnt_hold_ffff", 64'(o_sat_cnt), 64'hFFFF);
`else
    send(pack(65536, -65536, 65536, -65536), 1, 4, 0);
    drain();
    check("cnt_tied_zero", 64'(o_sat_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
